// File: rtl/dpram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dpram_port_ctrl
// Purpose  : Request controller for one port of a 16x8 true dual-port RAM.
//            Buffers read/write commands in a small FIFO, sequences the RAM
//            re/we/addr strobes, owns the shared data bus while writing and
//            returns read data over a valid/ready response channel.
// Options  : DPRAM_PORT_CTRL_STATS_EN adds saturating wr_count/rd_count
//            outputs counting completed writes and captured reads.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_port_ctrl #(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int CMD_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data,
    output logic          busy
`ifdef DPRAM_PORT_CTRL_STATS_EN
    ,
    output logic [15:0]   wr_count,
    output logic [15:0]   rd_count
`endif
);

    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL_CNT = CW'(CMD_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD_LOAD = 2'd2,
        S_RD_CAP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic          fifo_wr_q   [CMD_DEPTH];
    logic [AW-1:0] fifo_addr_q [CMD_DEPTH];
    logic [DW-1:0] fifo_data_q [CMD_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          head_wr;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    assign fifo_full  = (count_q == C_FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head_wr    = fifo_wr_q[rd_ptr_q];
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    // Command storage; contents are meaningless while the entry is not valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr_q[wr_ptr_q]   <= cmd_wr;
            fifo_addr_q[wr_ptr_q] <= cmd_addr;
            fifo_data_q[wr_ptr_q] <= cmd_wdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t        state_q,     state_d;
    logic          mem_re_q,    mem_re_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_free;

    // A read may issue when the response slot is empty or is being drained
    // this cycle; its data is only captured two edges later.
    assign rsp_free = !rsp_valid_q || rsp_ready;

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_wr) begin
                        pop        = 1'b1;
                        mem_addr_d = head_addr;
                        wdata_d    = head_data;
                        mem_we_d   = 1'b1;
                        state_d    = S_WR;
                    end else if (rsp_free) begin
                        pop        = 1'b1;
                        mem_addr_d = head_addr;
                        mem_re_d   = 1'b1;
                        state_d    = S_RD_LOAD;
                    end
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_RD_LOAD: begin
                mem_re_d = 1'b1;
                state_d  = S_RD_CAP;
            end
            S_RD_CAP: begin
                rsp_rdata_d = mem_data;
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;

    // The bus is driven only while the write strobe is up, which never
    // overlaps the read strobe, and is released as soon as reset asserts.
    assign mem_data  = mem_we_q ? wdata_q : {DW{1'bz}};

`ifdef DPRAM_PORT_CTRL_STATS_EN
    logic [15:0] wr_count_q;
    logic [15:0] rd_count_q;

    // Saturating completion counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            if ((state_q == S_WR) && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if ((state_q == S_RD_CAP) && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`endif

endmodule
`default_nettype wire
